// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : MEM-stage load/store unit between the MIPS datapath and a
//             byte-addressed, word-wide data memory. One request at a time;
//             word-aligned accesses, read-modify-write for SB/SH, sign/zero
//             extension for sub-word loads, fault on illegal ops.
//  Options  : LSU_MISALIGN_TRAP_EN - when defined, misaligned LH/LHU/SH/LW/SW
//             requests fault without touching memory.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        req,
   input  logic [5:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic [31:0] memAddress,
   output logic [31:0] memWriteData,
   output logic        memRead,
   output logic        memWrite,
   input  logic [31:0] memReadData
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_MISALIGN = 1'b1;
`else
   localparam bit TRAP_MISALIGN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t      state;
   logic [5:0]  op_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;   // only the low half is needed for SB/SH merges

   logic        legal;
   logic        misaligned;
   logic        trap;

   // Sign/zero-extend the addressed lane of a read word (little-endian lanes)
   function automatic logic [31:0] load_extend(input logic [5:0]  f_op,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f_op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'h0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   // Replace one byte (SB) or halfword (SH) lane of the read word with store data
   function automatic logic [31:0] store_merge(input logic [5:0]  f_op,
                                               input logic [1:0]  lane,
                                               input logic [15:0] data,
                                               input logic [31:0] word);
      logic [31:0] m;
      m = word;
      if (f_op == OP_SB)
         m[{lane, 3'b000} +: 8] = data[7:0];
      else
         m[{lane[1], 4'b0000} +: 16] = data;
      return m;
   endfunction

   // Classify the incoming request: legality and natural alignment
   always_comb begin
      legal      = 1'b1;
      misaligned = 1'b0;
      case (op)
         OP_LB, OP_LBU, OP_SB:  misaligned = 1'b0;
         OP_LH, OP_LHU, OP_SH:  misaligned = addr[0];
         OP_LW, OP_SW:          misaligned = |addr[1:0];
         default:               legal      = 1'b0;
      endcase
      trap = !legal || (TRAP_MISALIGN && misaligned);
   end

   // Request sequencer; every output is a register so nothing on the memory
   // side depends combinationally on req
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state        <= S_IDLE;
         op_q         <= 6'h0;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0;
         busy         <= 1'b0;
         done         <= 1'b0;
         fault        <= 1'b0;
         rdata        <= 32'h0;
         memAddress   <= 32'h0;
         memWriteData <= 32'h0;
         memRead      <= 1'b0;
         memWrite     <= 1'b0;
      end else begin
         done     <= 1'b0;
         fault    <= 1'b0;
         memRead  <= 1'b0;
         memWrite <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  op_q       <= op;
                  lane_q     <= addr[1:0];
                  wdata_q    <= wdata[15:0];
                  memAddress <= {addr[31:2], 2'b00};
                  busy       <= 1'b1;
                  if (trap) begin
                     state <= S_ERR;
                     done  <= 1'b1;
                     fault <= 1'b1;
                  end else if (op == OP_SW) begin
                     state        <= S_WR;
                     memWrite     <= 1'b1;
                     memWriteData <= wdata;
                  end else begin
                     // loads and the read half of SB/SH
                     state   <= S_RD;
                     memRead <= 1'b1;
                  end
               end
            end
            S_RD: begin
               if (op_q == OP_SB || op_q == OP_SH) begin
                  state        <= S_WR;
                  memWrite     <= 1'b1;
                  memWriteData <= store_merge(op_q, lane_q, wdata_q, memReadData);
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  rdata <= load_extend(op_q, lane_q, memReadData);
               end
            end
            S_WR: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE, S_ERR: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed, table-driven bench for load_store_unit with a small
//             word-wide memory model; expectations follow the
//             LSU_MISALIGN_TRAP_EN setting of the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        req = 1'b0;
   logic [5:0]  op = 6'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        busy, done, fault, memRead, memWrite;
   logic [31:0] rdata, memAddress, memWriteData, memReadData;

   logic [31:0] mem [0:63];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_idx = 6'h0;
   logic [31:0] bd_data = 32'h0;

   int checks = 0;
   int errors = 0;
   logic [31:0] hold = 32'h0;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          is_load;
      logic [31:0] exp_rdata;
      bit          exp_fault;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs[$];

   always #5 Clk = ~Clk;

   load_store_unit dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .req          (req),
      .op           (op),
      .addr         (addr),
      .wdata        (wdata),
      .busy         (busy),
      .done         (done),
      .rdata        (rdata),
      .fault        (fault),
      .memAddress   (memAddress),
      .memWriteData (memWriteData),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .memReadData  (memReadData)
   );

   // Memory model: combinational read, write on rising edge
   assign memReadData = mem[memAddress[7:2]];
   always @(posedge Clk) begin
      if (bd_we)
         mem[bd_idx] <= bd_data;
      else if (memWrite)
         mem[memAddress[7:2]] <= memWriteData;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bd_write(input logic [5:0] idx, input logic [31:0] data);
      @(negedge Clk);
      bd_we = 1'b1; bd_idx = idx; bd_data = data;
      @(negedge Clk);
      bd_we = 1'b0;
   endtask

   function automatic vec_t mk(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                               input bit ld, input logic [31:0] er, input bit ef,
                               input int lat, input int nr, input int nw, input logic [31:0] ewd);
      vec_t v;
      v.op = o; v.addr = a; v.wdata = w; v.is_load = ld; v.exp_rdata = er;
      v.exp_fault = ef; v.exp_lat = lat; v.exp_rd = nr; v.exp_wr = nw; v.exp_wd = ewd;
      return v;
   endfunction

   // Shorthands for the three request shapes
   function automatic vec_t ld(input logic [5:0] o, input logic [31:0] a, input logic [31:0] er);
      return mk(o, a, 32'h0, 1'b1, er, 1'b0, 2, 1, 0, 32'h0);
   endfunction
   function automatic vec_t st(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                               input logic [31:0] ewd);
      return mk(o, a, w, 1'b0, 32'h0, 1'b0, (o == 6'h2B) ? 2 : 3, (o == 6'h2B) ? 0 : 1, 1, ewd);
   endfunction
   function automatic vec_t flt(input logic [5:0] o, input logic [31:0] a);
      return mk(o, a, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int lat, nrd, nwr, nboth, addr_bad;
      logic [31:0] wd_seen, exp_r;
      string tag;
      lat = 1; nrd = 0; nwr = 0; nboth = 0; addr_bad = 0; wd_seen = 32'h0;
      tag = $sformatf("v%0d", idx);
      @(negedge Clk);
      req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
      @(negedge Clk);
      req = 1'b0;
      while (1) begin
         if (memRead === 1'b1) nrd++;
         if (memWrite === 1'b1) begin nwr++; wd_seen = memWriteData; end
         if (memRead === 1'b1 && memWrite === 1'b1) nboth++;
         if (memAddress !== (v.addr & ~32'h3)) addr_bad++;
         if (done === 1'b1 || lat >= 12) break;
         @(negedge Clk);
         lat++;
      end
      exp_r = (v.is_load && !v.exp_fault) ? v.exp_rdata : hold;
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_fault"}, {31'h0, fault}, {31'h0, v.exp_fault});
      chk({tag, "_rdata"}, rdata, exp_r);
      chk({tag, "_reads"}, nrd, v.exp_rd);
      chk({tag, "_writes"}, nwr, v.exp_wr);
      chk({tag, "_rd_wr_overlap"}, nboth, 0);
      if (v.exp_wr > 0) chk({tag, "_wdata"}, wd_seen, v.exp_wd);
      if (!v.exp_fault) chk({tag, "_addr_stable"}, addr_bad, 0);
      @(negedge Clk);
      chk({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
      hold = exp_r;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- vector table (memory word 0x10 starts as 0x8899AABB) ----
      vecs.push_back(ld(6'h23, 32'h10, 32'h8899AABB));
      vecs.push_back(ld(6'h20, 32'h13, 32'hFFFFFF88));
      vecs.push_back(ld(6'h24, 32'h13, 32'h00000088));
      vecs.push_back(ld(6'h21, 32'h12, 32'hFFFF8899));
      vecs.push_back(ld(6'h25, 32'h10, 32'h0000AABB));
      vecs.push_back(ld(6'h20, 32'h11, 32'hFFFFFFAA));
      vecs.push_back(ld(6'h24, 32'h10, 32'h000000BB));
      vecs.push_back(ld(6'h21, 32'h10, 32'hFFFFAABB));
      vecs.push_back(ld(6'h25, 32'h12, 32'h00008899));
      vecs.push_back(st(6'h28, 32'h11, 32'h12345677, 32'h889977BB));
      vecs.push_back(ld(6'h23, 32'h10, 32'h889977BB));
      vecs.push_back(st(6'h29, 32'h12, 32'hCAFE1234, 32'h123477BB));
      vecs.push_back(ld(6'h23, 32'h10, 32'h123477BB));
      vecs.push_back(st(6'h2B, 32'h14, 32'hDEADBEEF, 32'hDEADBEEF));
      vecs.push_back(ld(6'h23, 32'h14, 32'hDEADBEEF));
      vecs.push_back(st(6'h28, 32'h17, 32'h000000A5, 32'hA5ADBEEF));
      vecs.push_back(ld(6'h20, 32'h17, 32'hFFFFFFA5));
      vecs.push_back(ld(6'h24, 32'h16, 32'h000000AD));
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(flt(6'h23, 32'h12));
`else
      vecs.push_back(ld(6'h23, 32'h12, 32'h123477BB));
`endif
      vecs.push_back(flt(6'h00, 32'h10));
      vecs.push_back(flt(6'h22, 32'h10));
      vecs.push_back(flt(6'h2A, 32'h14));
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(flt(6'h29, 32'h11));
      vecs.push_back(ld(6'h23, 32'h10, 32'h123477BB));
      vecs.push_back(flt(6'h21, 32'h13));
`else
      vecs.push_back(st(6'h29, 32'h11, 32'h0000ABCD, 32'h1234ABCD));
      vecs.push_back(ld(6'h23, 32'h10, 32'h1234ABCD));
      vecs.push_back(ld(6'h21, 32'h13, 32'h00001234));
`endif

      // ---- reset asserted before any clock edge ----
      #1 Rst = 1'b0;
      #1;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_fault", {31'h0, fault}, 32'h0);
      chk("rst_memRead", {31'h0, memRead}, 32'h0);
      chk("rst_memWrite", {31'h0, memWrite}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_memAddress", memAddress, 32'h0);
      chk("rst_memWriteData", memWriteData, 32'h0);

      bd_write(6'd4, 32'h8899AABB);
      bd_write(6'd5, 32'h00000000);
      bd_write(6'd8, 32'h11223344);
      @(negedge Clk);
      Rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_vec(i, vecs[i]);

      // ---- req held high across a LW: one access, re-accept only from IDLE ----
      @(negedge Clk);
      req = 1'b1; op = 6'h23; addr = 32'h14; wdata = 32'h0;
      @(negedge Clk);
      chk("hold_c1_memRead", {31'h0, memRead}, 32'h1);
      chk("hold_c1_busy", {31'h0, busy}, 32'h1);
      @(negedge Clk);
      chk("hold_c2_done", {31'h0, done}, 32'h1);
      chk("hold_c2_memRead", {31'h0, memRead}, 32'h0);
      @(negedge Clk);
      chk("hold_c3_busy", {31'h0, busy}, 32'h0);
      chk("hold_c3_memRead", {31'h0, memRead}, 32'h0);
      @(negedge Clk);
      chk("hold_c4_memRead", {31'h0, memRead}, 32'h1);
      req = 1'b0;
      @(negedge Clk);
      chk("hold_c5_done", {31'h0, done}, 32'h1);
      chk("hold_c5_rdata", rdata, 32'hA5ADBEEF);
      @(negedge Clk);

      // ---- reset landing in WR of an SB: write must be abandoned ----
      @(negedge Clk);
      req = 1'b1; op = 6'h28; addr = 32'h20; wdata = 32'h000000FF;
      @(negedge Clk);
      req = 1'b0;
      begin
         int guard;
         guard = 0;
         while (memWrite !== 1'b1 && guard < 6) begin
            @(negedge Clk);
            guard++;
         end
         chk("rstwr_reached_wr", {31'h0, memWrite}, 32'h1);
      end
      #2 Rst = 1'b0;
      #1;
      chk("rstwr_memWrite", {31'h0, memWrite}, 32'h0);
      chk("rstwr_busy", {31'h0, busy}, 32'h0);
      chk("rstwr_done", {31'h0, done}, 32'h0);
      @(posedge Clk);
      #1;
      chk("rstwr_mem_unchanged", mem[8], 32'h11223344);
      chk("rstwr_rdata", rdata, 32'h0);
      @(negedge Clk);
      Rst = 1'b1;
      hold = 32'h0;

      // ---- unit still usable after the abandoned request ----
      run_vec(100, ld(6'h23, 32'h20, 32'h11223344));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit between the MIPS datapath and the byte-addressed data memory. Accepts one load or store request at a time, forms word-aligned memory accesses, and performs read-modify-write for byte and halfword stores. It also sign- or zero-extends loaded bytes and halfwords and flags misaligned or illegal requests. It sits in the MEM stage and drives the data memory's address, write-data, read-strobe and write-strobe inputs.

## Interface
- No parameters; data and address paths are fixed at 32 bits.
- Clk  in  1  sole clock; all state updates on rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- req  in  1  request valid; sampled only when busy=0.
- op  in  6  MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- addr  in  32  byte address.
- wdata  in  32  store data; byte/halfword taken from low bits.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; held until next load completes.
- fault  out  1  valid with done; misaligned or illegal op, no memory access made.
- memAddress  out  32  word-aligned address (addr & ~3).
- memWriteData  out  32  little-endian word to write.
- memRead  out  1  read strobe.
- memWrite  out  1  write strobe; memory writes on the rising edge where it is high.
- memReadData  in  32  combinational read word, {byte+3, byte+2, byte+1, byte+0}.

## Operation
- States: IDLE, RD, WR, DONE, ERR. memRead=1 only in RD. memWrite=1 only in WR. All outputs decode from registered state/data; no combinational path from req.
- IDLE: on req=1, latch op, addr and wdata, then:
  - loads go to RD
  - SW goes to WR
  - SB/SH go to RD
  - misaligned or illegal op goes to ERR
- RD: capture memReadData at the edge.
  - Loads go to DONE and update rdata.
  - SB/SH go to WR with the merged word.
- WR: SW presents wdata. SB places wdata[7:0] in lane addr[1:0]; SH places wdata[15:0] in lane addr[1]. Remaining lanes come from the captured word. Next state DONE.
- DONE: done=1, fault=0, then go to IDLE.
- ERR: done=1, fault=1, then go to IDLE. rdata is unchanged.
- Lane select is little-endian: byte k is bits [8k+7:8k]. LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Any other op value is illegal.
- req while busy=1 is ignored, not queued. A new req is accepted only in IDLE, i.e. the cycle after done at the earliest.

## Timing
- Reset (Rst=0) forces immediately, regardless of Clk: state IDLE; busy, done, fault, memRead, memWrite = 0; rdata, memAddress, memWriteData = 0.
- Reset mid-operation abandons the request. If reset lands in WR, memWrite falls asynchronously and no write occurs.
- Latency from accepting edge to done-high cycle:
  - load, SW: 2 cycles
  - SB/SH: 3 cycles
  - ERR: 1 cycle
- memAddress is stable for the whole request. memRead and memWrite each last exactly one cycle per access and are never high together.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests go to ERR with fault=1 and no memory access.
- LSU_MISALIGN_TRAP_EN undefined: misalignment is not checked. addr low bits are still used for lane select, the access proceeds at addr & ~3, and fault is asserted only for illegal ops.

## Test plan
- LW 0x10 with memory word 0x8899AABB -> memRead one cycle with memAddress=0x10; done 2 cycles after accept; rdata=0x8899AABB; fault=0.
- LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
- SB 0x11, wdata=0x12345677 -> RD then WR; memWriteData=0x889977BB; memWrite one cycle; done 3 cycles after accept; a following LW 0x10 returns 0x889977BB.
- LW 0x12:
  - with macro: no strobes; done+fault the next cycle.
  - without macro: reads 0x10; fault=0.
  - op=0x00: done+fault in either build.
- SB issued, Rst pulled low during WR -> memWrite drops without a clock edge; busy=0, done=0; memory word unchanged.
- req held high during a LW -> exactly one access; second request accepted only after done.
